// File: rtl/bcd_display_scanner_pkg.sv
// rtl/bcd_display_scanner_pkg.sv - shared BCD types and anode helpers for the display scanner
package bcd_disp_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] bcd_t;

  function automatic logic is_valid_bcd(bcd_t d);
    return (d <= BCD_MAX);
  endfunction

  // Eight-bit wide so it serves any legal digit count; callers size-cast the result.
  function automatic logic [7:0] onehot_anode(logic [2:0] idx, logic active_low);
    logic [7:0] oh;
    oh = 8'b0000_0001 << idx;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// rtl/bcd_display_scanner_if.sv - load/digit inputs and scan outputs of the display scanner
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IW = $clog2(NUM_DIGITS > 2 ? NUM_DIGITS : 2);

  logic                    load_i;
  logic [4*NUM_DIGITS-1:0] digits_i;
  logic [3:0]              bcd_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [IW-1:0]           digit_idx_o;
  logic                    bcd_err_o;

  modport master (
    output load_i, digits_i,
    input  bcd_o, an_o, digit_idx_o, bcd_err_o
  );

  modport slave (
    input  load_i, digits_i,
    output bcd_o, an_o, digit_idx_o, bcd_err_o
  );

endinterface

// File: rtl/bcd_display_scanner_refresh_tick_gen.sv
// rtl/bcd_display_scanner_refresh_tick_gen.sv - prescaler producing one tick per digit slot
module refresh_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  // With PRESCALE=1 the counter sits at 0 and the tick is permanently high.
  assign tick_o = (cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexes shadowed BCD digits onto one decoder; optional BLANK_LEADING_ZERO_EN
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int PRESCALE         = 50000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_scanner_if.slave  bus
);

  localparam int IW = $clog2(NUM_DIGITS > 2 ? NUM_DIGITS : 2);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  logic          tick;
  logic [IW-1:0] idx;
  bcd_t          shadow    [NUM_DIGITS];
  bcd_t          nib_clean [NUM_DIGITS];
  logic          load_bad;
  logic [NUM_DIGITS-1:0] an_next;

  refresh_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // Out-of-range nibbles are replaced by 0 so the decoder never sees 10-15.
  always_comb begin
    load_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_clean[i] = is_valid_bcd(bus.digits_i[4*i +: 4]) ? bus.digits_i[4*i +: 4] : '0;
      load_bad     = load_bad | !is_valid_bcd(bus.digits_i[4*i +: 4]);
    end
  end

`ifdef BLANK_LEADING_ZERO_EN
  logic [NUM_DIGITS-1:0] blank;

  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (shadow[i] != '0);
      blank[i] = !seen && (i != 0);
    end
  end

  always_comb begin
    an_next = blank[idx] ? AN_IDLE
                         : NUM_DIGITS'(onehot_anode(3'(idx), ANODE_ACTIVE_LOW != 0));
  end
`else
  always_comb begin
    an_next = NUM_DIGITS'(onehot_anode(3'(idx), ANODE_ACTIVE_LOW != 0));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
      bus.bcd_err_o <= 1'b0;
    end else if (bus.load_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= nib_clean[i];
      bus.bcd_err_o <= load_bad;
    end
  end

  // Output stage lags idx/shadow by one cycle so the decoder input changes cleanly on an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bcd_o       <= '0;
      bus.an_o        <= AN_IDLE;
      bus.digit_idx_o <= '0;
    end else begin
      bus.bcd_o       <= shadow[idx];
      bus.an_o        <= an_next;
      bus.digit_idx_o <= idx;
    end
  end

endmodule
